// File: rtl/pet_stat_engine.sv
// pet_stat_engine
//   Virtual-pet statistics core. A prescaler turns the system clock into a
//   slow tick. Every DECAY_TICKS ticks, all stats drop by one. Refill pulses
//   raise individual stats. The pet's overall condition is tracked as
//   OK / NEEDY / CRITICAL / DEAD. DEAD is sticky until reset.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst        in   synchronous active-high reset
//   refill     in   [NUM_STATS] one-cycle refill pulses, bit i -> stat i
//   test_mode  in   level, selects the shorter TEST_DIV prescale
//   stat_vals  out  [NUM_STATS*STAT_W] packed stats, stat i at [i*STAT_W +: STAT_W]
//   low_flags  out  [NUM_STATS] stat i <= LOW_THR
//   pet_state  out  [2] 00 OK, 01 NEEDY, 10 CRITICAL, 11 DEAD (state register)
//   tick       out  one-cycle pulse per prescaler wrap
module pet_stat_engine #(
  parameter int NUM_STATS   = 5,
  parameter int STAT_W      = 3,
  parameter int TICK_DIV    = 50_000_000,
  parameter int TEST_DIV    = 5_000_000,
  parameter int DECAY_TICKS = 10,
  parameter int INC_STEP    = 2,
  parameter int LOW_THR     = 2,
  parameter int DEAD_TICKS  = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_STATS-1:0]          refill,
  input  logic                          test_mode,
  output logic [NUM_STATS*STAT_W-1:0]   stat_vals,
  output logic [NUM_STATS-1:0]          low_flags,
  output logic [1:0]                    pet_state,
  output logic                          tick
);

  localparam int PW_RAW = (TICK_DIV > TEST_DIV) ? $clog2(TICK_DIV) : $clog2(TEST_DIV);
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
  localparam int DW_RAW = $clog2(DECAY_TICKS);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int ZW_RAW = $clog2(DEAD_TICKS);
  localparam int ZW     = (ZW_RAW < 1) ? 1 : ZW_RAW;
  localparam int MAX    = (1 << STAT_W) - 1;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_NEEDY = 2'b01,
    ST_CRIT  = 2'b10,
    ST_DEAD  = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic                r_tick;
  logic                r_tm_prev;
  logic [DW-1:0]       r_dcnt;
  logic [ZW-1:0]       r_zcnt;
  logic [STAT_W-1:0]   r_stat     [NUM_STATS];
  logic [STAT_W-1:0]   w_stat_nxt [NUM_STATS];
  logic [PW-1:0]       w_div_m1;
  logic                w_dead;
  logic                w_decay;
  logic                w_any_zero;
  logic                w_nxt_zero;
  logic                w_nxt_low;
  logic                w_die;
  int                  w_sum;

  assign w_dead   = (r_state == ST_DEAD);
  assign w_div_m1 = test_mode ? PW'(TEST_DIV - 1) : PW'(TICK_DIV - 1);
  // Decay event coincides with the tick that wraps the decay counter.
  assign w_decay  = r_tick && !w_dead && (r_dcnt == DW'(DECAY_TICKS - 1));
  // Death fires on the tick that would bring the zero counter to DEAD_TICKS.
  assign w_die    = r_tick && !w_dead && w_any_zero && (r_zcnt == ZW'(DEAD_TICKS - 1));

  // Prescaler and tick. A test_mode change restarts the count silently.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_tm_prev <= test_mode;
    end else begin
      r_tm_prev <= test_mode;
      if (test_mode != r_tm_prev) begin
        r_presc <= '0;
        r_tick  <= 1'b0;
      end else if (r_presc == w_div_m1) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end
    end
  end

  // Decay and zero counters, both frozen once dead.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_dcnt <= '0;
      r_zcnt <= '0;
    end else if (!w_dead) begin
      if (r_tick) begin
        r_dcnt <= (r_dcnt == DW'(DECAY_TICKS - 1)) ? '0 : r_dcnt + DW'(1);
      end
      if (!w_any_zero) begin
        r_zcnt <= '0;
      end else if (r_tick) begin
        r_zcnt <= r_zcnt + ZW'(1);
      end
    end
  end

  // Next stat values: refill and decay combine before clamping, so the
  // intermediate sum is computed in int width and cannot overflow.
  always_comb begin
    w_sum      = 0;
    w_any_zero = 1'b0;
    w_nxt_zero = 1'b0;
    w_nxt_low  = 1'b0;
    for (int i = 0; i < NUM_STATS; i++) begin
      w_stat_nxt[i] = r_stat[i];
      w_any_zero    = w_any_zero | (r_stat[i] == '0);
      if (!w_dead) begin
        w_sum = int'(r_stat[i]) + (refill[i] ? INC_STEP : 0) - (w_decay ? 1 : 0);
        if (w_sum < 0)        w_stat_nxt[i] = '0;
        else if (w_sum > MAX) w_stat_nxt[i] = STAT_W'(MAX);
        else                  w_stat_nxt[i] = STAT_W'(w_sum);
      end
      w_nxt_zero = w_nxt_zero | (w_stat_nxt[i] == '0);
      w_nxt_low  = w_nxt_low  | (int'(w_stat_nxt[i]) <= LOW_THR);
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_STATS; i++) begin
      if (Rst) r_stat[i] <= STAT_W'(MAX);
      else     r_stat[i] <= w_stat_nxt[i];
    end
  end

  // Condition FSM. Classified from the next stat values so that pet_state
  // always agrees with stat_vals in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_dead || w_die)  w_state_nxt = ST_DEAD;
    else if (w_nxt_zero)  w_state_nxt = ST_CRIT;
    else if (w_nxt_low)   w_state_nxt = ST_NEEDY;
    else                  w_state_nxt = ST_OK;
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_OK;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    stat_vals = '0;
    low_flags = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      stat_vals[i*STAT_W +: STAT_W] = r_stat[i];
      low_flags[i] = (int'(r_stat[i]) <= LOW_THR);
    end
  end

  assign pet_state = r_state;
  assign tick      = r_tick;

endmodule

// File: tb/tb_pet_stat_engine.sv
module tb_pet_stat_engine;

  localparam int N        = 5;
  localparam int W        = 3;
  localparam int TICK_DIV = 4;
  localparam int TEST_DIV = 2;
  localparam int DECAY    = 2;
  localparam int INC      = 2;
  localparam int LOW      = 2;
  localparam int DEADT    = 3;
  localparam int MAX      = 7;

  // ---------------- clock / reset / DUT ----------------
  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [N-1:0]     refill = '0;
  logic             test_mode = 1'b0;
  logic [N*W-1:0]   stat_vals;
  logic [N-1:0]     low_flags;
  logic [1:0]       pet_state;
  logic             tick;

  always #5 Clk = ~Clk;

  pet_stat_engine #(
    .NUM_STATS(N), .STAT_W(W), .TICK_DIV(TICK_DIV), .TEST_DIV(TEST_DIV),
    .DECAY_TICKS(DECAY), .INC_STEP(INC), .LOW_THR(LOW), .DEAD_TICKS(DEADT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .refill(refill), .test_mode(test_mode),
    .stat_vals(stat_vals), .low_flags(low_flags), .pet_state(pet_state), .tick(tick)
  );

  // ---------------- behavioural model ----------------
  int  checks   = 0;
  int  failures = 0;
  bit  m_valid  = 0;
  int  m_stat [N];
  int  m_presc, m_dcnt, m_zcnt, m_state;
  bit  m_tick, m_dead, m_tm_prev;

  task automatic model_step(input bit rst, input bit [N-1:0] rf, input bit tm);
    bit t, any0, dec, die, nz, nl;
    int v, dv;
    if (rst) begin
      for (int i = 0; i < N; i++) m_stat[i] = MAX;
      m_presc = 0; m_tick = 0; m_dcnt = 0; m_zcnt = 0;
      m_dead = 0; m_state = 0; m_tm_prev = tm;
      return;
    end
    t = m_tick;
    any0 = 0;
    for (int i = 0; i < N; i++) if (m_stat[i] == 0) any0 = 1;
    dec = t && !m_dead && (m_dcnt == DECAY - 1);
    die = 0;
    if (!m_dead) begin
      if (!any0) m_zcnt = 0;
      else if (t) begin
        m_zcnt++;
        if (m_zcnt >= DEADT) die = 1;
      end
      for (int i = 0; i < N; i++) begin
        v = m_stat[i] + (rf[i] ? INC : 0) - (dec ? 1 : 0);
        m_stat[i] = (v < 0) ? 0 : (v > MAX) ? MAX : v;
      end
      if (t) m_dcnt = (m_dcnt + 1) % DECAY;
    end
    dv = tm ? TEST_DIV : TICK_DIV;
    if (tm != m_tm_prev) begin
      m_presc = 0; m_tick = 0;
    end else if (m_presc == dv - 1) begin
      m_presc = 0; m_tick = 1;
    end else begin
      m_presc++; m_tick = 0;
    end
    m_tm_prev = tm;
    if (die) m_dead = 1;
    nz = 0; nl = 0;
    for (int i = 0; i < N; i++) begin
      if (m_stat[i] == 0)   nz = 1;
      if (m_stat[i] <= LOW) nl = 1;
    end
    m_state = m_dead ? 3 : nz ? 2 : nl ? 1 : 0;
  endtask

  function automatic logic [N*W-1:0] model_pack();
    logic [N*W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = W'(m_stat[i]);
    return p;
  endfunction

  function automatic logic [N-1:0] model_low();
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i] = (m_stat[i] <= LOW);
    return f;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      check("stat_vals", 32'(stat_vals), 32'(model_pack()));
      check("low_flags", 32'(low_flags), 32'(model_low()));
      check("pet_state", 32'(pet_state), 32'(m_state));
      check("tick",      32'(tick),      32'(m_tick));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit [N-1:0] rf, input bit tm);
    Rst = rst; refill = rf; test_mode = tm;
    @(posedge Clk);
    model_step(rst, rf, tm);
    m_valid = 1;
    #1;
  endtask

  bit tm_r;

  initial begin
    // Reset state, then idle decay.
    step(1, '0, 0);
    check("rst_stats", 32'(stat_vals), 32'h7FFF);
    check("rst_state", 32'(pet_state), 0);
    check("rst_low",   32'(low_flags), 0);
    check("rst_tick",  32'(tick),      0);
    for (int i = 0; i < 4; i++) step(0, '0, 0);
    check("first_tick", 32'(tick), 1);
    for (int i = 0; i < 12; i++) step(0, '0, 0);
    check("stats_6", 32'(stat_vals), 32'h6DB6);
    step(0, '0, 0);
    check("stats_5", 32'(stat_vals), 32'h5B6D);
    check("state_ok_5", 32'(pet_state), 0);

    // test_mode toggle restarts the prescaler without a tick.
    step(0, '0, 1);
    check("tm_toggle_notick", 32'(tick), 0);
    step(0, '0, 1);
    check("tm_cnt1_notick", 32'(tick), 0);
    step(0, '0, 1);
    check("tm_tick2", 32'(tick), 1);

    // Saturating refill at MAX.
    step(1, '0, 0);
    step(0, 5'b00001, 0);
    check("refill_sat", 32'(stat_vals[2:0]), 7);

    // Starve to death in test mode, refills ignored, reset revives.
    step(1, '0, 1);
    for (int i = 0; i < 70; i++) step(0, '0, 1);
    check("dead_state", 32'(pet_state), 3);
    check("dead_stats", 32'(stat_vals), 0);
    step(0, 5'b11111, 1);
    check("dead_frozen", 32'(stat_vals), 0);
    check("dead_sticky", 32'(pet_state), 3);
    step(1, 5'b11111, 1);
    check("rst_from_dead", 32'(stat_vals), 32'h7FFF);
    check("rst_dead_state", 32'(pet_state), 0);

    // Randomized operation against the model.
    tm_r = 0;
    for (int c = 0; c < 3000; c++) begin
      bit [N-1:0] rf;
      bit rs;
      for (int b = 0; b < N; b++) rf[b] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) tm_r = ~tm_r;
      rs = ($urandom_range(0, 399) == 0);
      step(rs, rf, tm_r);
    end

    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
